// File: rtl/snake_pattern_decoder.sv
// snake_pattern_decoder
//   Watches a 7-segment frame stream produced by the snake segment generators. It recovers the
//   snake position (0..7), the rotation direction and whether a direction lock is established.
//   Segment bit map: [0]=a [1]=b [2]=c [3]=d [4]=e [5]=f [6]=g.
//
// Parameters
//   LOCK_STEPS  consecutive same-direction adjacent steps needed to lock (1..15)
//   ERR_W       width of the saturating error counter
//
// Ports
//   i_clk        clock, rising edge
//   i_rst        synchronous reset, active high
//   i_valid      i_segment holds a new frame this cycle
//   i_segment    segment frame
//   o_count      last decoded snake index
//   o_dir        1 = clockwise (index +1 mod 8), 0 = counter-clockwise
//   o_locked     direction lock established
//   o_step       one-cycle pulse: an adjacent step was accepted
//   o_err        one-cycle pulse: illegal frame or broken sequence
//   o_err_count  saturating error tally
//
// Configuration
//   SNAKE_DEC_ERRCNT_EN  when defined, o_err_count counts o_err pulses and saturates at all ones.
//                        When undefined there is no counter and o_err_count is tied to 0.
module snake_pattern_decoder #(
  parameter int unsigned LOCK_STEPS = 4,
  parameter int unsigned ERR_W      = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic [6:0]       i_segment,
  output logic [2:0]       o_count,
  output logic             o_dir,
  output logic             o_locked,
  output logic             o_step,
  output logic             o_err,
  output logic [ERR_W-1:0] o_err_count
);

  localparam logic [3:0] LockSteps = 4'(LOCK_STEPS);

  typedef enum logic [1:0] {StIdle, StAcq, StLock} state_e;

  state_e     state_q, state_d;
  logic [2:0] count_q, count_d;
  logic       dir_q, dir_d;
  logic       locked_q, locked_d;
  logic       step_q, step_d;
  logic       err_q, err_d;
  logic [3:0] run_q, run_d;

  logic       legal;
  logic [2:0] idx;
  logic [2:0] delta;
  logic       is_fwd, is_bwd, is_adj;

  // Frame decode: one segment pattern per snake position.
  always_comb begin
    legal = 1'b1;
    idx   = 3'd0;
    case (i_segment)
      7'h03:   idx = 3'd0;
      7'h42:   idx = 3'd1;
      7'h50:   idx = 3'd2;
      7'h18:   idx = 3'd3;
      7'h0C:   idx = 3'd4;
      7'h44:   idx = 3'd5;
      7'h60:   idx = 3'd6;
      7'h21:   idx = 3'd7;
      default: legal = 1'b0;
    endcase
  end

  // 3-bit wrap makes 7->0 a +1 step and 0->7 a -1 step.
  assign delta  = idx - count_q;
  assign is_fwd = (delta == 3'd1);
  assign is_bwd = (delta == 3'd7);
  assign is_adj = is_fwd | is_bwd;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    dir_d    = dir_q;
    locked_d = locked_q;
    run_d    = run_q;
    step_d   = 1'b0;
    err_d    = 1'b0;

    if (i_valid) begin
      unique case (state_q)
        StIdle: begin
          if (legal) begin
            count_d = idx;
            run_d   = 4'd0;
            state_d = StAcq;
          end else begin
            err_d = 1'b1;
          end
        end

        StAcq: begin
          if (!legal) begin
            err_d   = 1'b1;
            run_d   = 4'd0;
            state_d = StIdle;
          end else if (is_adj) begin
            count_d = idx;
            step_d  = 1'b1;
            dir_d   = is_fwd;
            // A direction change restarts the run at this step.
            if (run_q == 4'd0 || is_fwd == dir_q) begin
              run_d = run_q + 4'd1;
            end else begin
              run_d = 4'd1;
            end
            if (run_d >= LockSteps) begin
              locked_d = 1'b1;
              state_d  = StLock;
            end
          end else if (delta != 3'd0) begin
            err_d   = 1'b1;
            count_d = idx;
            run_d   = 4'd0;
          end
        end

        StLock: begin
          if (!legal) begin
            err_d    = 1'b1;
            locked_d = 1'b0;
            run_d    = 4'd0;
            state_d  = StIdle;
          end else if (delta == 3'd0) begin
            // Repeated frame: hold.
          end else if ((is_fwd && dir_q) || (is_bwd && !dir_q)) begin
            count_d = idx;
            step_d  = 1'b1;
          end else if (is_adj) begin
            // Reversal still counts as the first step of the new direction.
            err_d    = 1'b1;
            step_d   = 1'b1;
            locked_d = 1'b0;
            dir_d    = ~dir_q;
            count_d  = idx;
            run_d    = 4'd1;
            state_d  = StAcq;
          end else begin
            err_d    = 1'b1;
            locked_d = 1'b0;
            count_d  = idx;
            run_d    = 4'd0;
            state_d  = StAcq;
          end
        end

        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= StIdle;
      count_q  <= 3'd0;
      dir_q    <= 1'b1;
      locked_q <= 1'b0;
      step_q   <= 1'b0;
      err_q    <= 1'b0;
      run_q    <= 4'd0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      dir_q    <= dir_d;
      locked_q <= locked_d;
      step_q   <= step_d;
      err_q    <= err_d;
      run_q    <= run_d;
    end
  end

  assign o_count  = count_q;
  assign o_dir    = dir_q;
  assign o_locked = locked_q;
  assign o_step   = step_q;
  assign o_err    = err_q;

`ifdef SNAKE_DEC_ERRCNT_EN
  logic [ERR_W-1:0] err_cnt_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      err_cnt_q <= '0;
    end else if (err_d && (err_cnt_q != {ERR_W{1'b1}})) begin
      err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign o_err_count = err_cnt_q;
`else
  assign o_err_count = '0;
`endif

endmodule

// File: tb/tb_snake_pattern_decoder.sv
module tb_snake_pattern_decoder;

`ifdef SNAKE_DEC_ERRCNT_EN
  localparam int unsigned ErrW = 2;
`else
  localparam int unsigned ErrW = 8;
`endif

  logic            clk;
  logic            rst;
  logic            valid;
  logic [6:0]      segment;
  logic [2:0]      count;
  logic            dir;
  logic            locked;
  logic            step;
  logic            err;
  logic [ErrW-1:0] err_count;

  int n_cmp = 0;
  int n_bad = 0;

  snake_pattern_decoder #(
    .LOCK_STEPS(4),
    .ERR_W     (ErrW)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_valid    (valid),
    .i_segment  (segment),
    .o_count    (count),
    .o_dir      (dir),
    .o_locked   (locked),
    .o_step     (step),
    .o_err      (err),
    .o_err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // All tasks start and end at a falling edge; outputs are sampled there.
  task automatic send(input logic [6:0] s);
    valid   = 1'b1;
    segment = s;
    @(negedge clk);
    valid   = 1'b0;
    segment = 7'h7F;
  endtask

  task automatic idle(input int n);
    valid   = 1'b0;
    segment = 7'h7F;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // count, dir, locked, step, err in one go
  task automatic expect_out(input string tag, input logic [2:0] c, input logic d,
                            input logic l, input logic s, input logic e);
    check({tag, ".count"},  32'(count),  32'(c));
    check({tag, ".dir"},    32'(dir),    32'(d));
    check({tag, ".locked"}, 32'(locked), 32'(l));
    check({tag, ".step"},   32'(step),   32'(s));
    check({tag, ".err"},    32'(err),    32'(e));
  endtask

  initial begin
    logic [ErrW-1:0] exp_cnt [5];
    rst     = 1'b0;
    valid   = 1'b0;
    segment = 7'h00;
    @(negedge clk);
    do_reset();
    expect_out("reset", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("reset.errcnt", 32'(err_count), 32'd0);

    // CW stream to lock
    send(7'h03); expect_out("cw0", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    send(7'h42); expect_out("cw1", 3'd1, 1'b1, 1'b0, 1'b1, 1'b0);
    send(7'h50); expect_out("cw2", 3'd2, 1'b1, 1'b0, 1'b1, 1'b0);
    send(7'h18); expect_out("cw3", 3'd3, 1'b1, 1'b0, 1'b1, 1'b0);
    send(7'h0C); expect_out("cw4", 3'd4, 1'b1, 1'b1, 1'b1, 1'b0);

    // Illegal frame while locked, then recover
    send(7'h7F); expect_out("ill", 3'd4, 1'b1, 1'b0, 1'b0, 1'b1);
    send(7'h03); expect_out("rec", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    // Legal non-adjacent jump in ACQ
    send(7'h18); expect_out("jump", 3'd3, 1'b1, 1'b0, 1'b0, 1'b1);

    // CCW stream
    do_reset();
    send(7'h21); expect_out("ccw7", 3'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    send(7'h60); expect_out("ccw6", 3'd6, 1'b0, 1'b0, 1'b1, 1'b0);
    send(7'h44); expect_out("ccw5", 3'd5, 1'b0, 1'b0, 1'b1, 1'b0);

    // Wrap 0->7 and 7->0
    do_reset();
    send(7'h03); expect_out("wr0", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    send(7'h21); expect_out("wr07", 3'd7, 1'b0, 1'b0, 1'b1, 1'b0);
    send(7'h03); expect_out("wr70", 3'd0, 1'b1, 1'b0, 1'b1, 1'b0);

    // Lock at index 2, then reverse
    do_reset();
    send(7'h60); send(7'h21); send(7'h03); send(7'h42);
    expect_out("pre2", 3'd1, 1'b1, 1'b0, 1'b1, 1'b0);
    send(7'h50); expect_out("lk2", 3'd2, 1'b1, 1'b1, 1'b1, 1'b0);
    send(7'h42); expect_out("rev", 3'd1, 1'b0, 1'b0, 1'b1, 1'b1);
    // Reversal left run=1: three more CCW steps lock
    send(7'h03); expect_out("rv2", 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    send(7'h21); expect_out("rv3", 3'd7, 1'b0, 1'b0, 1'b1, 1'b0);
    send(7'h60); expect_out("rv4", 3'd6, 1'b0, 1'b1, 1'b1, 1'b0);

    // Repeats and valid gaps hold everything, no pulses
    send(7'h60); expect_out("rep1", 3'd6, 1'b0, 1'b1, 1'b0, 1'b0);
    send(7'h60); expect_out("rep2", 3'd6, 1'b0, 1'b1, 1'b0, 1'b0);
    send(7'h60); expect_out("rep3", 3'd6, 1'b0, 1'b1, 1'b0, 1'b0);
    send(7'h44); expect_out("lstep", 3'd5, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(2);     expect_out("gap", 3'd5, 1'b0, 1'b1, 1'b0, 1'b0);

    // Reset wins over a valid frame
    rst = 1'b1; valid = 1'b1; segment = 7'h0C;
    @(negedge clk);
    rst = 1'b0; valid = 1'b0;
    expect_out("rstpri", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Error counter: five illegal frames from IDLE
`ifdef SNAKE_DEC_ERRCNT_EN
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
`else
    exp_cnt = '{default: '0};
`endif
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send(7'h00);
      check($sformatf("errcnt%0d", i), 32'(err_count), 32'(exp_cnt[i]));
      check($sformatf("errpulse%0d", i), 32'(err), 32'd1);
    end
    do_reset();
    check("errcnt.rst", 32'(err_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
